pht_update_ctrl: RTL and testbench

PHT_UPDATE_CTRL -- requirements
Module: pht_update_ctrl

---
 rtl/pht_update_ctrl_pkg.sv | 35 +++
 rtl/pht_update_ctrl_fifo.sv | 51 +++++
 rtl/pht_update_ctrl.sv | 135 +++++++++++++
 tb/tb_pht_update_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pht_update_ctrl_pkg.sv
// Shared types, widths and counter arithmetic for the PHT update controller.
package pht_update_ctrl_pkg;

    localparam int PHT_IDX_W = 11;
    localparam int CTR_W     = 2;
    localparam int UPD_W     = PHT_IDX_W + CTR_W + 1;

    localparam logic [CTR_W-1:0]     PHT_INIT_DEF = 2'b01;
    localparam logic [PHT_IDX_W-1:0] PHT_LAST_IDX = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pht_state_e;

    typedef struct packed {
        logic [PHT_IDX_W-1:0] idx;
        logic [CTR_W-1:0]     ctr;
        logic                 taken;
    } upd_entry_t;

    // Two-bit saturating counter step: count up on taken, down on not-taken.
    function automatic logic [CTR_W-1:0] sat_count(input logic [CTR_W-1:0] c,
                                                   input logic taken);
        logic [CTR_W-1:0] res;
        res = c;
        if (taken) begin
            if (c != '1) res = c + 1'b1;
        end else begin
            if (c != '0) res = c - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_update_ctrl_fifo.sv
// Small update queue with registered occupancy and registered ready flag.
module upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             ready
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_nxt;

    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle's enqueue/dequeue, used for count and ready.
    always_comb begin
        cnt_nxt = count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    // Entry storage carries no reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= cnt_nxt;
            ready <= (cnt_nxt != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/pht_update_ctrl.sv
// PHT update controller: init sweep, then queued counter updates with forwarding.
module pht_update_ctrl
    import pht_update_ctrl_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [CTR_W-1:0]  PHT_INIT   = PHT_INIT_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  BPU__Stall,
    input  logic                  Upd_Valid,
    output logic                  Upd_Ready,
    input  logic [PHT_IDX_W-1:0]  Upd_Index,
    input  logic [CTR_W-1:0]      Upd_Counter,
    input  logic                  Upd_Taken,
    output logic [PHT_IDX_W-1:0]  PHT_Write_Index,
    output logic [CTR_W-1:0]      PHT_Write_Data,
    output logic                  PHT_Write_En,
    output logic                  GHR_Write_Data,
    output logic                  GHR_Write_En,
    output logic                  Init_Busy,
    output logic [2:0]            Pending
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    pht_state_e           state, nxt_state;
    logic [PHT_IDX_W-1:0] sweep_idx, nxt_sweep_idx;
    logic                 fwd_valid, nxt_fwd_valid;
    logic [PHT_IDX_W-1:0] fwd_index, nxt_fwd_index;
    logic [CTR_W-1:0]     fwd_data, nxt_fwd_data;
    logic                 nxt_pht_we, nxt_ghr_we, nxt_ghr_wd, nxt_busy;
    logic [PHT_IDX_W-1:0] nxt_pht_wi;
    logic [CTR_W-1:0]     nxt_pht_wd;

    logic [UPD_W-1:0]     fifo_rd_data;
    logic [CNT_W-1:0]     fifo_count;
    upd_entry_t           head;
    logic                 enq, deq, fwd_hit;
    logic [CTR_W-1:0]     cur_ctr, new_ctr;

    assign enq     = Upd_Valid & Upd_Ready;
    assign deq     = (state == ST_RUN) & ~BPU__Stall & (fifo_count != '0);
    assign head    = upd_entry_t'(fifo_rd_data);
    assign fwd_hit = fwd_valid && (fwd_index == head.idx);
    assign cur_ctr = fwd_hit ? fwd_data : head.ctr;
    assign new_ctr = sat_count(cur_ctr, head.taken);
    assign Pending = 3'(fifo_count);

    upd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UPD_W),
        .CNT_W (CNT_W)
    ) u_upd_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .wr_en   (enq),
        .wr_data ({Upd_Index, Upd_Counter, Upd_Taken}),
        .rd_en   (deq),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .ready   (Upd_Ready)
    );

    // Next-state and next-output logic; strobes default low so they pulse once.
    always_comb begin
        nxt_state     = state;
        nxt_sweep_idx = sweep_idx;
        nxt_fwd_valid = fwd_valid;
        nxt_fwd_index = fwd_index;
        nxt_fwd_data  = fwd_data;
        nxt_pht_we    = 1'b0;
        nxt_pht_wi    = PHT_Write_Index;
        nxt_pht_wd    = PHT_Write_Data;
        nxt_ghr_we    = 1'b0;
        nxt_ghr_wd    = GHR_Write_Data;
        nxt_busy      = Init_Busy;
        case (state)
            ST_INIT: begin
                if (!BPU__Stall) begin
                    nxt_pht_we    = 1'b1;
                    nxt_pht_wi    = sweep_idx;
                    nxt_pht_wd    = PHT_INIT;
                    nxt_sweep_idx = sweep_idx + 1'b1;
                    if (sweep_idx == PHT_LAST_IDX) begin
                        nxt_state = ST_RUN;
                        nxt_busy  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (deq) begin
                    nxt_pht_we    = (new_ctr != cur_ctr);
                    nxt_pht_wi    = head.idx;
                    nxt_pht_wd    = new_ctr;
                    nxt_ghr_we    = 1'b1;
                    nxt_ghr_wd    = head.taken;
                    nxt_fwd_valid = 1'b1;
                    nxt_fwd_index = head.idx;
                    nxt_fwd_data  = new_ctr;
                end
            end
        endcase
    end

    // State, sweep counter, forwarding register and all registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state           <= ST_INIT;
            sweep_idx       <= '0;
            fwd_valid       <= 1'b0;
            fwd_index       <= '0;
            fwd_data        <= '0;
            PHT_Write_En    <= 1'b0;
            PHT_Write_Index <= '0;
            PHT_Write_Data  <= '0;
            GHR_Write_En    <= 1'b0;
            GHR_Write_Data  <= 1'b0;
            Init_Busy       <= 1'b1;
        end else begin
            state           <= nxt_state;
            sweep_idx       <= nxt_sweep_idx;
            fwd_valid       <= nxt_fwd_valid;
            fwd_index       <= nxt_fwd_index;
            fwd_data        <= nxt_fwd_data;
            PHT_Write_En    <= nxt_pht_we;
            PHT_Write_Index <= nxt_pht_wi;
            PHT_Write_Data  <= nxt_pht_wd;
            GHR_Write_En    <= nxt_ghr_we;
            GHR_Write_Data  <= nxt_ghr_wd;
            Init_Busy       <= nxt_busy;
        end
    end

endmodule

// File: tb/tb_pht_update_ctrl.sv
// Directed self-checking bench for pht_update_ctrl.
module tb_pht_update_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        BPU__Stall;
    logic        Upd_Valid;
    logic        Upd_Ready;
    logic [10:0] Upd_Index;
    logic [1:0]  Upd_Counter;
    logic        Upd_Taken;
    logic [10:0] PHT_Write_Index;
    logic [1:0]  PHT_Write_Data;
    logic        PHT_Write_En;
    logic        GHR_Write_Data;
    logic        GHR_Write_En;
    logic        Init_Busy;
    logic [2:0]  Pending;

    int total = 0;
    int bad   = 0;

    pht_update_ctrl #(
        .FIFO_DEPTH (4),
        .PHT_INIT   (2'b01)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .BPU__Stall      (BPU__Stall),
        .Upd_Valid       (Upd_Valid),
        .Upd_Ready       (Upd_Ready),
        .Upd_Index       (Upd_Index),
        .Upd_Counter     (Upd_Counter),
        .Upd_Taken       (Upd_Taken),
        .PHT_Write_Index (PHT_Write_Index),
        .PHT_Write_Data  (PHT_Write_Data),
        .PHT_Write_En    (PHT_Write_En),
        .GHR_Write_Data  (GHR_Write_Data),
        .GHR_Write_En    (GHR_Write_En),
        .Init_Busy       (Init_Busy),
        .Pending         (Pending)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one update across the next rising edge, then withdraw it.
    task automatic applyStimulus(input logic [10:0] idx, input logic [1:0] ctr, input logic taken);
        Upd_Valid   = 1'b1;
        Upd_Index   = idx;
        Upd_Counter = ctr;
        Upd_Taken   = taken;
        @(posedge CLK);
        #1 Upd_Valid = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input logic pen, input logic [10:0] idx,
                              input logic [1:0] data, input logic gen, input logic gdata);
        checkOutput({tag, "_pht_en"}, 32'(PHT_Write_En), 32'(pen));
        if (pen) begin
            checkOutput({tag, "_pht_idx"}, 32'(PHT_Write_Index), 32'(idx));
            checkOutput({tag, "_pht_data"}, 32'(PHT_Write_Data), 32'(data));
        end
        checkOutput({tag, "_ghr_en"}, 32'(GHR_Write_En), 32'(gen));
        if (gen) checkOutput({tag, "_ghr_data"}, 32'(GHR_Write_Data), 32'(gdata));
    endtask

    initial begin
        int writes;
        int idx_err;
        int ghr_seen;
        int done;
        int hit;

        RST_N = 1'b0; BPU__Stall = 1'b0; Upd_Valid = 1'b0;
        Upd_Index = '0; Upd_Counter = '0; Upd_Taken = 1'b0;

        #12;
        checkOutput("rst_ready", 32'(Upd_Ready), 0);
        checkOutput("rst_busy", 32'(Init_Busy), 1);
        checkOutput("rst_pht_en", 32'(PHT_Write_En), 0);
        checkOutput("rst_ghr_en", 32'(GHR_Write_En), 0);
        checkOutput("rst_pending", 32'(Pending), 0);
        checkOutput("rst_pht_idx", 32'(PHT_Write_Index), 0);

        // Release reset and offer an update that must sit queued through the sweep.
        #1 RST_N = 1'b1;
        Upd_Valid = 1'b1; Upd_Index = 11'd100; Upd_Counter = 2'd0; Upd_Taken = 1'b0;
        @(negedge CLK);
        checkOutput("ready_after_rst", 32'(Upd_Ready), 1);

        writes = 0; idx_err = 0; ghr_seen = 0; done = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1) Upd_Valid = 1'b0;
            if (PHT_Write_En === 1'b1) begin
                if (PHT_Write_Index !== 11'(writes) || PHT_Write_Data !== 2'b01) idx_err++;
                writes++;
            end
            if (GHR_Write_En !== 1'b0) ghr_seen++;
            if (Init_Busy === 1'b0) begin
                done = 1;
                break;
            end
            @(negedge CLK);
        end
        checkOutput("sweep_done", 32'(done), 1);
        checkOutput("sweep_writes", 32'(writes), 2048);
        checkOutput("sweep_idx_err", 32'(idx_err), 0);
        checkOutput("sweep_ghr", 32'(ghr_seen), 0);
        checkOutput("sweep_pending", 32'(Pending), 1);

        @(negedge CLK);
        checkWrite("init_queued", 1'b0, 11'd0, 2'd0, 1'b1, 1'b0);
        checkOutput("init_queued_pending", 32'(Pending), 0);

        $display("[TB] basic update");
        applyStimulus(11'd5, 2'b01, 1'b1);
        @(negedge CLK);
        checkWrite("upd5_early", 1'b0, 11'd0, 2'd0, 1'b0, 1'b0);
        @(negedge CLK);
        checkWrite("upd5", 1'b1, 11'd5, 2'b10, 1'b1, 1'b1);
        @(negedge CLK);
        checkWrite("upd5_pulse", 1'b0, 11'd0, 2'd0, 1'b0, 1'b0);

        $display("[TB] saturated update");
        applyStimulus(11'd9, 2'd3, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        checkWrite("upd9_sat", 1'b0, 11'd0, 2'd0, 1'b1, 1'b1);

        $display("[TB] forwarding");
        applyStimulus(11'd7, 2'd1, 1'b1);
        applyStimulus(11'd7, 2'd1, 1'b1);
        @(negedge CLK);
        checkWrite("fwd_first", 1'b1, 11'd7, 2'd2, 1'b1, 1'b1);
        @(negedge CLK);
        checkWrite("fwd_second", 1'b1, 11'd7, 2'd3, 1'b1, 1'b1);

        $display("[TB] stall fill and drain");
        @(negedge CLK);
        BPU__Stall = 1'b1;
        applyStimulus(11'd20, 2'd0, 1'b1);
        applyStimulus(11'd21, 2'd2, 1'b0);
        applyStimulus(11'd22, 2'd1, 1'b0);
        applyStimulus(11'd20, 2'd2, 1'b1);
        Upd_Valid = 1'b1; Upd_Index = 11'd30; Upd_Counter = 2'd0; Upd_Taken = 1'b0;
        @(negedge CLK);
        checkOutput("full_pending", 32'(Pending), 4);
        checkOutput("full_ready", 32'(Upd_Ready), 0);
        checkWrite("full_stalled", 1'b0, 11'd0, 2'd0, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("full_refused", 32'(Pending), 4);
        checkWrite("full_stalled2", 1'b0, 11'd0, 2'd0, 1'b0, 1'b0);
        BPU__Stall = 1'b0;
        @(posedge CLK);
        #1 Upd_Valid = 1'b0;
        @(negedge CLK);
        checkWrite("drain1", 1'b1, 11'd20, 2'd1, 1'b1, 1'b1);
        checkOutput("drain1_pending", 32'(Pending), 3);
        checkOutput("drain1_ready", 32'(Upd_Ready), 1);
        @(negedge CLK);
        checkWrite("drain2", 1'b1, 11'd21, 2'd1, 1'b1, 1'b0);
        @(negedge CLK);
        checkWrite("drain3", 1'b1, 11'd22, 2'd0, 1'b1, 1'b0);
        @(negedge CLK);
        checkWrite("drain4", 1'b1, 11'd20, 2'd3, 1'b1, 1'b1);
        checkOutput("drain4_pending", 32'(Pending), 0);
        @(negedge CLK);
        checkWrite("drain_idle", 1'b0, 11'd0, 2'd0, 1'b0, 1'b0);

        $display("[TB] reset mid-sweep");
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        hit = 0;
        for (int i = 0; i < 1200; i++) begin
            if (i == 2) begin
                Upd_Valid = 1'b1; Upd_Index = 11'd50; Upd_Counter = 2'd1; Upd_Taken = 1'b1;
            end
            if (i == 3) Upd_Valid = 1'b0;
            if (PHT_Write_En === 1'b1 && PHT_Write_Index === 11'd1000) begin
                hit = 1;
                break;
            end
            @(negedge CLK);
        end
        checkOutput("midsweep_reached", 32'(hit), 1);
        checkOutput("midsweep_pending", 32'(Pending), 1);
        RST_N = 1'b0;
        #1;
        checkOutput("arst_pht_en", 32'(PHT_Write_En), 0);
        checkOutput("arst_pht_idx", 32'(PHT_Write_Index), 0);
        checkOutput("arst_pht_data", 32'(PHT_Write_Data), 0);
        checkOutput("arst_ghr_en", 32'(GHR_Write_En), 0);
        checkOutput("arst_ghr_data", 32'(GHR_Write_Data), 0);
        checkOutput("arst_busy", 32'(Init_Busy), 1);
        checkOutput("arst_ready", 32'(Upd_Ready), 0);
        checkOutput("arst_pending", 32'(Pending), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checkWrite("restart", 1'b1, 11'd0, 2'b01, 1'b0, 1'b0);
        checkOutput("restart_busy", 32'(Init_Busy), 1);
        checkOutput("restart_ready", 32'(Upd_Ready), 1);
        checkOutput("restart_pending", 32'(Pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
